// File: rtl/and_gate_selftest_ctrl.sv
// rtl/and_gate_selftest_ctrl.sv - BIST sequencer sweeping the AND gate truth table
// Optional feature macro: SELFTEST_NAND_MODE_EN (adds nand_mode, expects NAND response)
module and_gate_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef SELFTEST_NAND_MODE_EN
  input  logic       nand_mode,
`endif
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [7:0] PASS_LAST   = 8'((PASSES > 0) ? PASSES - 1 : 0);

  logic [2:0] state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] pass_idx_q, pass_idx_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       nand_q, nand_d;
  logic       exp_y;
  logic       in_run;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_idx_d   = pass_idx_q;
    settle_cnt_d = settle_cnt_q;
    pass_d       = pass_q;
    fail_vec_d   = fail_vec_q;
    err_cnt_d    = err_cnt_q;
    nand_d       = nand_q;
    done_d       = 1'b0;

    exp_y = vec_q[1] & vec_q[0];
    if (nand_q) begin
      exp_y = ~exp_y;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_APPLY;
          vec_d      = 2'd0;
          pass_idx_d = 8'd0;
          fail_vec_d = 4'd0;
          err_cnt_d  = 8'd0;
          pass_d     = 1'b0;
`ifdef SELFTEST_NAND_MODE_EN
          nand_d     = nand_mode;
`else
          nand_d     = 1'b0;
`endif
        end
      end
      ST_APPLY: begin
        if (SETTLE_CYCLES > 0) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LAST;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (gate_y != exp_y) begin
          fail_vec_d[vec_q] = 1'b1;
          if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_APPLY;
        end else if (pass_idx_q < PASS_LAST) begin
          pass_idx_d = pass_idx_q + 8'd1;
          vec_d      = 2'd0;
          state_d    = ST_APPLY;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // fail_vec_q already holds the last SAMPLE result here
        done_d  = 1'b1;
        pass_d  = (fail_vec_q == 4'd0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Gate drive follows the upcoming state so it is stable for the whole vector
    in_run   = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    busy_d   = in_run;
    gate_a_d = in_run & vec_d[1];
    gate_b_d = in_run & vec_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= 2'd0;
      pass_idx_q   <= 8'd0;
      settle_cnt_q <= 8'd0;
      gate_a_q     <= 1'b0;
      gate_b_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_vec_q   <= 4'd0;
      err_cnt_q    <= 8'd0;
      nand_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_idx_q   <= pass_idx_d;
      settle_cnt_q <= settle_cnt_d;
      gate_a_q     <= gate_a_d;
      gate_b_q     <= gate_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_vec_q   <= fail_vec_d;
      err_cnt_q    <= err_cnt_d;
      nand_q       <= nand_d;
    end
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_and_gate_selftest_ctrl.sv
// tb/tb_and_gate_selftest_ctrl.sv - directed bench for and_gate_selftest_ctrl
module tb_and_gate_selftest_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_s = 3'b000;
  logic [2:0] y_s, a_s, b_s, busy_s, done_s, pass_s;
  logic [3:0] fv_s [3];
  logic [7:0] ec_s [3];
  int         gmode = 0;
  logic [1:0] seq [64];
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt0 = 0;
`ifdef SELFTEST_NAND_MODE_EN
  logic       nand_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  // 0: AND, 1: stuck-at-1, 2: stuck-at-0, 3: NAND
  function automatic logic model(input int m, input logic a, input logic b);
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return ~(a & b);
      default: return a & b;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) y_s[i] = model(gmode, a_s[i], b_s[i]);
  end

  always @(posedge clk) if (done_s[0]) done_cnt0 <= done_cnt0 + 1;

  and_gate_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
`ifdef SELFTEST_NAND_MODE_EN
    .nand_mode(nand_mode),
`endif
    .gate_y(y_s[0]), .gate_a(a_s[0]), .gate_b(b_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .fail_vec(fv_s[0]), .err_cnt(ec_s[0]));

  and_gate_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(3)) u_dut_p3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
`ifdef SELFTEST_NAND_MODE_EN
    .nand_mode(nand_mode),
`endif
    .gate_y(y_s[1]), .gate_a(a_s[1]), .gate_b(b_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .fail_vec(fv_s[1]), .err_cnt(ec_s[1]));

  and_gate_selftest_ctrl #(.SETTLE_CYCLES(0), .PASSES(1)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]),
`ifdef SELFTEST_NAND_MODE_EN
    .nand_mode(nand_mode),
`endif
    .gate_y(y_s[2]), .gate_a(a_s[2]), .gate_b(b_s[2]), .busy(busy_s[2]),
    .done(done_s[2]), .pass(pass_s[2]), .fail_vec(fv_s[2]), .err_cnt(ec_s[2]));

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero0(input string tag);
    check_eq({tag, "_a"}, a_s[0], 0);
    check_eq({tag, "_b"}, b_s[0], 0);
    check_eq({tag, "_busy"}, busy_s[0], 0);
    check_eq({tag, "_done"}, done_s[0], 0);
    check_eq({tag, "_pass"}, pass_s[0], 0);
    check_eq({tag, "_fail_vec"}, fv_s[0], 0);
    check_eq({tag, "_err_cnt"}, ec_s[0], 0);
  endtask

  // cyc = number of edges after the start-sampling edge until done is seen high
  task automatic run(input int idx, input bit repulse, output int cyc);
    @(negedge clk);
    start_s[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_s[idx] = 1'b0;
    cyc = 0;
    seq[0] = {a_s[idx], b_s[idx]};
    while (!done_s[idx] && cyc < 300) begin
      start_s[idx] = (repulse && cyc == 5);
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) seq[cyc] = {a_s[idx], b_s[idx]};
    end
    start_s[idx] = 1'b0;
    if (cyc >= 300) check_eq("run_timeout", cyc, 0);
  endtask

  initial begin
    int cyc, d0, first, second;

    repeat (3) @(posedge clk);
    #1;
    check_zero0("reset");
    @(negedge clk);
    rst_n = 1'b1;

    gmode = 0;
    run(0, 1'b0, cyc);
    check_eq("and_done_cycles", cyc, 17);
    check_eq("and_pass", pass_s[0], 1);
    check_eq("and_fail_vec", fv_s[0], 0);
    check_eq("and_err_cnt", ec_s[0], 0);
    for (int k = 0; k < 16; k++) check_eq($sformatf("ab_seq_%0d", k), seq[k], k / 4);
    check_eq("ab_in_done", seq[16], 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("and_pass_held", pass_s[0], 1);
    check_eq("and_done_low", done_s[0], 0);

    gmode = 1;
    run(0, 1'b0, cyc);
    check_eq("s1_done_cycles", cyc, 17);
    check_eq("s1_pass", pass_s[0], 0);
    check_eq("s1_fail_vec", fv_s[0], 4'b0111);
    check_eq("s1_err_cnt", ec_s[0], 3);
    repeat (2) @(posedge clk);

    gmode = 0;
    run(0, 1'b1, cyc);
    check_eq("repulse_done_cycles", cyc, 17);
    check_eq("repulse_pass", pass_s[0], 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("repulse_no_restart", busy_s[0], 0);

    gmode = 2;
    run(1, 1'b0, cyc);
    check_eq("p3_done_cycles", cyc, 49);
    check_eq("p3_fail_vec", fv_s[1], 4'b1000);
    check_eq("p3_err_cnt", ec_s[1], 3);
    check_eq("p3_pass", pass_s[1], 0);
    repeat (2) @(posedge clk);

    gmode = 0;
    run(2, 1'b0, cyc);
    check_eq("s0_done_cycles", cyc, 9);
    check_eq("s0_pass", pass_s[2], 1);
    repeat (2) @(posedge clk);

    gmode = 1;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("mid_vec2_a", a_s[0], 1);
    check_eq("mid_err_cnt", ec_s[0], 2);
    d0 = done_cnt0;
    rst_n = 1'b0;
    #1;
    check_zero0("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt0 - d0, 0);
    gmode = 0;
    run(0, 1'b0, cyc);
    check_eq("post_rst_cycles", cyc, 17);
    check_eq("post_rst_pass", pass_s[0], 1);
    repeat (2) @(posedge clk);

    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    first = -1;
    second = -1;
    while (second < 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_s[0]) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    start_s[0] = 1'b0;
    check_eq("b2b_first_done", first, 17);
    check_eq("b2b_second_done", second, 35);
    repeat (3) @(posedge clk);

`ifdef SELFTEST_NAND_MODE_EN
    gmode = 3;
    @(negedge clk);
    start_s[0] = 1'b1;
    nand_mode = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    nand_mode = 1'b0;
    cyc = 0;
    while (!done_s[0] && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("nand_done_cycles", cyc, 17);
    check_eq("nand_pass", pass_s[0], 1);
    check_eq("nand_fail_vec", fv_s[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
